zle_2_decode: RTL and testbench
===============================

Name: zle_2_decode

Overview:
Zero run-length decoder, the inverse of the zle_2 encoder path.
- Consumes a token stream of literals and zero-run tokens.
- Emits the expanded 3-bit data stream, one value per cycle.
- Sits between the encoded-stream source and the downstream data consumer.
- Uses valid/ready handshakes on both sides and a single registered output stage, so it is fully backpressurable.

Parameters:
DW, 3, data value width (literal payload and output width)
CW, 4, run-count field width; a run token encodes 1..2^CW zeros
(Token width is CW+1; DW <= CW is required.)

Ports:
clock  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-low
i_d  input  CW+1  token; bit CW = 1 means run token, bit CW = 0 means literal in bits [DW-1:0]
i_valid  input  1  token present on i_d
i_ready  output  1  decoder accepts the token this cycle
o_d  output  DW  decoded value
o_valid  output  1  o_d holds a valid value
o_ready  input  1  consumer takes o_d this cycle
run_active  output  1  high while a multi-zero run is still being expanded (status/debug)

Behaviour:
- Reset (async, reset=0) values: state=S_PASS, rem=0, o_valid=0, o_d=0, run_active=0, i_ready=0 while reset is asserted. Reset mid-run discards the remaining zeros and any held output.
- Slot free: `free = !o_valid || o_ready`.
- Input accept: when `i_valid && i_ready`. `i_ready = (state==S_PASS) && free`. Combinational from state, o_valid and o_ready; no dependency on i_valid.
- Output transfer: when `o_valid && o_ready`. If the output is not refilled in the same cycle, o_valid falls the next cycle.
- State S_PASS:
  - Literal accepted: o_d <= i_d[DW-1:0], o_valid <= 1.
  - Run token accepted with c = i_d[CW-1:0]:
    - o_d <= 0, o_valid <= 1.
    - If c==0 (run of 1), stay in S_PASS.
    - Otherwise rem <= c (zeros still owed) and go to S_RUN.
  - No accept while free: o_valid <= 0.
- State S_RUN:
  - i_ready=0 and run_active=1.
  - When free: o_d <= 0, o_valid <= 1, rem <= rem-1.
  - If rem==1 before the decrement, go to S_PASS.
  - When not free: hold everything.
- Latency and throughput:
  - Latency is 1 cycle from token accept to o_valid.
  - With o_ready held high, output is 1 value/cycle.
  - A run token of count c occupies c+1 output cycles and blocks input for c cycles after acceptance.
- Backpressure: while `o_valid && !o_ready`, o_d, o_valid, rem and state are all frozen.
- Run length boundaries:
  - Max count c = 2^CW-1 expands to exactly 2^CW zeros; rem arithmetic is CW bits and never wraps.
  - Min count c = 0 expands to exactly 1 zero.
- Literal value 0 (never produced by the encoder) is passed through as a single zero. It does not raise an error.
- Simultaneous events: in S_PASS, an output transfer and a new accept in the same cycle are allowed. This gives back-to-back tokens with no bubble.
- Undefined state encoding: go to S_PASS with o_valid=0.

Test Plan:
1. After reset release, o_ready=1, send literals 5, 3, 7 on consecutive cycles -> o_d = 5, 3, 7 on the 3 following cycles; o_valid continuous; i_ready stays 1.
2. Run token 0x13 (run, c=3), then literal 2 presented -> o_d = 0, 0, 0, 0, then 2; i_ready low for exactly 3 cycles; run_active high for 3 cycles.
3. Run token 0x1F (c=15) -> exactly 16 zeros, then S_PASS. Run token 0x10 (c=0) -> exactly 1 zero with no i_ready drop.
4. Run token 0x12 with o_ready toggled 1,0,0,1,1 -> o_d=0 held stable while stalled; exactly 3 zero transfers total; no value lost or duplicated.
5. Assert reset mid-run (after 2 of 8 zeros of token 0x17) -> o_valid=0 and i_ready=0 immediately. After release: state S_PASS, and next literal 4 -> o_d=4.
6. Random token stream, then feed the decoder output into a zle_2 encoder model -> round-trip output equals the original stream.

Source files
------------

// File: rtl/zle_2_decode_if.sv
// Token-in / data-out handshake bundle for the zero run-length decoder.
// The slave modport is the decoder side; the master modport is its environment.
interface zle_2_decode_if #(
    parameter int DW = 3,
    parameter int CW = 4
);
    logic [CW:0]   i_d;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] o_d;
    logic          o_valid;
    logic          o_ready;

    modport slave (
        input  i_d,
        input  i_valid,
        output i_ready,
        output o_d,
        output o_valid,
        input  o_ready
    );

    modport master (
        output i_d,
        output i_valid,
        input  i_ready,
        input  o_d,
        input  o_valid,
        output o_ready
    );
endinterface

// File: rtl/zle_2_decode.sv
// Zero run-length decoder: expands literal and zero-run tokens into a
// one-value-per-cycle data stream behind a single registered output stage.
module zle_2_decode #(
    parameter int DW = 3,
    parameter int CW = 4
) (
    input  logic           clock,
    input  logic           reset,
    zle_2_decode_if.slave  bus,
    output logic           run_active
);
    typedef enum logic [1:0] {
        S_PASS = 2'd0,
        S_RUN  = 2'd1
    } state_t;

    localparam logic [CW-1:0] C_ONE = {{(CW-1){1'b0}}, 1'b1};

    state_t        r_state;
    logic [CW-1:0] r_rem;
    logic [DW-1:0] r_d;
    logic          r_valid;

    state_t        w_state_nxt;
    logic [CW-1:0] w_rem_nxt;
    logic [DW-1:0] w_d_nxt;
    logic          w_valid_nxt;

    logic          w_free;
    logic          w_ready;
    logic          w_accept;
    logic          w_is_run;
    logic [CW-1:0] w_cnt;

    assign w_free   = !r_valid || bus.o_ready;
    // reset gates i_ready so the source never sees an accept while held in reset
    assign w_ready  = reset && (r_state == S_PASS) && w_free;
    assign w_accept = bus.i_valid && w_ready;
    assign w_is_run = bus.i_d[CW];
    assign w_cnt    = bus.i_d[CW-1:0];

    assign bus.i_ready = w_ready;
    assign bus.o_d     = r_d;
    assign bus.o_valid = r_valid;
    assign run_active  = (r_state == S_RUN);

    // Next state: accept tokens in S_PASS, emit owed zeros in S_RUN
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_d_nxt     = r_d;
        w_valid_nxt = r_valid;
        case (r_state)
            S_PASS: begin
                if (w_accept) begin
                    w_valid_nxt = 1'b1;
                    if (w_is_run) begin
                        w_d_nxt = '0;
                        if (w_cnt != '0) begin
                            w_rem_nxt   = w_cnt;
                            w_state_nxt = S_RUN;
                        end
                    end else begin
                        w_d_nxt = bus.i_d[DW-1:0];
                    end
                end else if (w_free) begin
                    w_valid_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (w_free) begin
                    w_d_nxt     = '0;
                    w_valid_nxt = 1'b1;
                    w_rem_nxt   = r_rem - C_ONE;
                    if (r_rem == C_ONE) begin
                        w_state_nxt = S_PASS;
                    end
                end
            end
            default: begin
                w_state_nxt = S_PASS;
                w_rem_nxt   = '0;
                w_d_nxt     = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output register; reset drops any pending run and held value
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_PASS;
            r_rem   <= '0;
            r_d     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_d     <= w_d_nxt;
            r_valid <= w_valid_nxt;
        end
    end
endmodule

// File: tb/tb_zle_2_decode.sv
// Directed and round-trip bench for the zero run-length decoder.
// Transfers are logged by a monitor; each test task checks its own results.
module tb_zle_2_decode;
    logic clock;
    logic reset;
    logic run_active;

    int passed;
    int total;

    bit   mon_en;
    bit   rnd_en;
    int   low_cnt;
    int   ra_cnt;
    logic [2:0] got[$];

    zle_2_decode_if #(.DW(3), .CW(4)) bus();

    zle_2_decode #(.DW(3), .CW(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .run_active(run_active)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Log per-cycle handshake state just before each edge
    always @(posedge clock) begin
        if (mon_en) begin
            if (!bus.i_ready) low_cnt++;
            if (run_active) ra_cnt++;
            if (bus.o_valid && bus.o_ready) got.push_back(bus.o_d);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (rnd_en) bus.o_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clr();
        got.delete();
        low_cnt = 0;
        ra_cnt  = 0;
    endtask

    task automatic send(input logic [4:0] tok);
        int n;
        n = 0;
        bus.i_d     = tok;
        bus.i_valid = 1'b1;
        #1;
        while (!bus.i_ready && n < 200) begin
            tick();
            #1;
            n++;
        end
        if (n >= 200) begin
            total++;
            $display("FAIL send_timeout tok=%h waited=%0d limit=200", tok, n);
        end
        tick();
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (bus.o_valid !== 1'b0)
            $display("FAIL rst_o_valid got=%b exp=0", bus.o_valid);
        else passed++;
        total++;
        if (bus.i_ready !== 1'b0)
            $display("FAIL rst_i_ready got=%b exp=0", bus.i_ready);
        else passed++;
        total++;
        if (bus.o_d !== 3'd0)
            $display("FAIL rst_o_d got=%0d exp=0", bus.o_d);
        else passed++;
        total++;
        if (run_active !== 1'b0)
            $display("FAIL rst_run_active got=%b exp=0", run_active);
        else passed++;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        total++;
        if (bus.i_ready !== 1'b1)
            $display("FAIL rel_i_ready got=%b exp=1", bus.i_ready);
        else passed++;
    endtask

    task automatic test_literals();
        logic [2:0] v[3];
        v = '{3'd5, 3'd3, 3'd7};
        for (int i = 0; i < 3; i++) begin
            bus.i_d     = {2'b00, v[i]};
            bus.i_valid = 1'b1;
            #1;
            total++;
            if (bus.i_ready !== 1'b1)
                $display("FAIL lit_i_ready[%0d] got=%b exp=1", i, bus.i_ready);
            else passed++;
            tick();
            total++;
            if (bus.o_valid !== 1'b1 || bus.o_d !== v[i])
                $display("FAIL lit_out[%0d] got=%b/%0d exp=1/%0d",
                         i, bus.o_valid, bus.o_d, v[i]);
            else passed++;
        end
        bus.i_valid = 1'b0;
        tick();
        total++;
        if (bus.o_valid !== 1'b0)
            $display("FAIL lit_drain got=%b exp=0", bus.o_valid);
        else passed++;
    endtask

    task automatic test_run3();
        logic [2:0] exp_q[$];
        exp_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
        clr();
        mon_en = 1'b1;
        send(5'h13);
        send(5'h02);
        repeat (4) tick();
        mon_en = 1'b0;
        total++;
        if (got !== exp_q)
            $display("FAIL run3_data got=%p exp=%p", got, exp_q);
        else passed++;
        total++;
        if (low_cnt !== 3)
            $display("FAIL run3_i_ready_low got=%0d exp=3", low_cnt);
        else passed++;
        total++;
        if (ra_cnt !== 3)
            $display("FAIL run3_run_active got=%0d exp=3", ra_cnt);
        else passed++;
    endtask

    task automatic test_run_bounds();
        int nz;
        clr();
        mon_en = 1'b1;
        send(5'h1F);
        repeat (20) tick();
        mon_en = 1'b0;
        nz = 0;
        foreach (got[i]) if (got[i] == 3'd0) nz++;
        total++;
        if (got.size() !== 16 || nz !== 16)
            $display("FAIL run_max_len got=%0d zeros=%0d exp=16", got.size(), nz);
        else passed++;
        total++;
        if (ra_cnt !== 15 || low_cnt !== 15)
            $display("FAIL run_max_block got=%0d/%0d exp=15/15", ra_cnt, low_cnt);
        else passed++;
        total++;
        if (run_active !== 1'b0 || bus.i_ready !== 1'b1)
            $display("FAIL run_max_end got=%b/%b exp=0/1", run_active, bus.i_ready);
        else passed++;
        clr();
        mon_en = 1'b1;
        send(5'h10);
        repeat (3) tick();
        mon_en = 1'b0;
        total++;
        if (got.size() !== 1 || got[0] !== 3'd0)
            $display("FAIL run_min_len got=%0d exp=1", got.size());
        else passed++;
        total++;
        if (low_cnt !== 0 || ra_cnt !== 0)
            $display("FAIL run_min_block got=%0d/%0d exp=0/0", low_cnt, ra_cnt);
        else passed++;
    endtask

    task automatic test_backpressure();
        bit pat[5];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        clr();
        mon_en = 1'b1;
        send(5'h12);
        for (int i = 0; i < 5; i++) begin
            bus.o_ready = pat[i];
            #1;
            if (!pat[i]) begin
                total++;
                if (bus.o_valid !== 1'b1 || bus.o_d !== 3'd0 || run_active !== 1'b1)
                    $display("FAIL bp_hold[%0d] got=%b/%0d/%b exp=1/0/1",
                             i, bus.o_valid, bus.o_d, run_active);
                else passed++;
            end
            tick();
        end
        bus.o_ready = 1'b1;
        mon_en = 1'b0;
        total++;
        if (got.size() !== 3)
            $display("FAIL bp_count got=%0d exp=3", got.size());
        else passed++;
        total++;
        if (bus.o_valid !== 1'b0)
            $display("FAIL bp_end_valid got=%b exp=0", bus.o_valid);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        clr();
        mon_en = 1'b1;
        send(5'h17);
        tick();
        tick();
        total++;
        if (got.size() !== 2)
            $display("FAIL mid_pre_count got=%0d exp=2", got.size());
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (bus.o_valid !== 1'b0 || bus.i_ready !== 1'b0 || run_active !== 1'b0)
            $display("FAIL mid_rst got=%b/%b/%b exp=0/0/0",
                     bus.o_valid, bus.i_ready, run_active);
        else passed++;
        tick();
        tick();
        reset = 1'b1;
        #1;
        total++;
        if (bus.i_ready !== 1'b1 || run_active !== 1'b0)
            $display("FAIL mid_rel got=%b/%b exp=1/0", bus.i_ready, run_active);
        else passed++;
        send(5'h04);
        total++;
        if (bus.o_valid !== 1'b1 || bus.o_d !== 3'd4)
            $display("FAIL mid_lit got=%b/%0d exp=1/4", bus.o_valid, bus.o_d);
        else passed++;
        repeat (2) tick();
        mon_en = 1'b0;
        total++;
        if (got.size() !== 3)
            $display("FAIL mid_total got=%0d exp=3", got.size());
        else passed++;
    endtask

    task automatic test_roundtrip();
        logic [4:0] src[$];
        logic [4:0] enc[$];
        bit prev_run;
        int cnt;
        prev_run = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!prev_run && $urandom_range(0, 2) == 0) begin
                src.push_back({1'b1, 4'($urandom_range(0, 15))});
                prev_run = 1'b1;
            end else begin
                src.push_back({2'b00, 3'($urandom_range(1, 7))});
                prev_run = 1'b0;
            end
        end
        clr();
        mon_en = 1'b1;
        rnd_en = 1'b1;
        foreach (src[i]) send(src[i]);
        repeat (300) tick();
        rnd_en = 1'b0;
        bus.o_ready = 1'b1;
        repeat (3) tick();
        mon_en = 1'b0;
        cnt = 0;
        foreach (got[i]) begin
            if (got[i] == 3'd0) begin
                cnt++;
                if (cnt == 16) begin
                    enc.push_back(5'h1F);
                    cnt = 0;
                end
            end else begin
                if (cnt > 0) enc.push_back({1'b1, 4'(cnt - 1)});
                cnt = 0;
                enc.push_back({2'b00, got[i]});
            end
        end
        if (cnt > 0) enc.push_back({1'b1, 4'(cnt - 1)});
        total++;
        if (enc.size() !== src.size())
            $display("FAIL rt_len got=%0d exp=%0d", enc.size(), src.size());
        else passed++;
        foreach (src[i]) begin
            total++;
            if (i >= enc.size())
                $display("FAIL rt_tok[%0d] got=missing exp=%h", i, src[i]);
            else if (enc[i] !== src[i])
                $display("FAIL rt_tok[%0d] got=%h exp=%h", i, enc[i], src[i]);
            else passed++;
        end
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        mon_en      = 1'b0;
        rnd_en      = 1'b0;
        reset       = 1'b0;
        bus.i_d     = '0;
        bus.i_valid = 1'b0;
        bus.o_ready = 1'b1;
        test_reset();
        tick();
        test_literals();
        test_run3();
        test_run_bounds();
        test_backpressure();
        test_reset_mid_run();
        test_roundtrip();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
